// File: rtl/systolic_skew_feeder_pkg.sv
// Shared types and packing helpers for the systolic operand skew feeder.
package systolic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FEED  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    function automatic int unsigned feed_len(input int unsigned n);
        return 2 * n - 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(2 * n);
    endfunction

    // LSB of A element (r,k) in the row-major packed matrix
    function automatic int unsigned a_elem_lsb(input int unsigned n, input int unsigned w,
                                               input int unsigned r, input int unsigned k);
        return (n * n - 1 - (r * n + k)) * w;
    endfunction

    // LSB of B element (k,c) in the column-major packed matrix
    function automatic int unsigned b_elem_lsb(input int unsigned n, input int unsigned w,
                                               input int unsigned k, input int unsigned c);
        return (n * n - 1 - (c * n + k)) * w;
    endfunction

endpackage

// File: rtl/systolic_skew_feeder_skew_lane_sel.sv
// One skewed lane: picks element (t - LANE) of a captured row/column, or padding.
module skew_lane_sel
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 3,
    parameter int unsigned LANE  = 0
) (
    input  logic [cnt_w(N)-1:0] t,
    input  logic [N*WIDTH-1:0]  vec,
    output logic                valid,
    output logic [WIDTH-1:0]    elem
);

    localparam int unsigned CNT_W = cnt_w(N);

    always_comb begin
        valid = 1'b0;
        elem  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (t == CNT_W'(LANE + k)) begin
                valid = 1'b1;
                elem  = vec[(N-1-k)*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// N x N operand feeder: captures A/B on START and streams them diagonally skewed into the PE array.
module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned N            = 3,
    parameter int unsigned DRAIN_CYCLES = N
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 STALL,
    input  logic [N*N*WIDTH-1:0] A_IN,
    input  logic [N*N*WIDTH-1:0] B_IN,
    output logic [N*WIDTH-1:0]   A_OUT,
    output logic [N*WIDTH-1:0]   B_OUT,
    output logic [N-1:0]         A_VALID,
    output logic [N-1:0]         B_VALID,
    output logic                 CLEAR,
    output logic                 BUSY,
    output logic                 DONE
);

    localparam int unsigned FEED_LEN = feed_len(N);
    localparam int unsigned CNT_W    = cnt_w(N);
    localparam int unsigned DRN_W    = $clog2(DRAIN_CYCLES + 1);

    state_t               state;
    logic [CNT_W-1:0]     step;
    logic [CNT_W-1:0]     t_next;
    logic [DRN_W-1:0]     drain_cnt;
    logic [N*N*WIDTH-1:0] a_cap;
    logic [N*N*WIDTH-1:0] b_cap;
    logic [N*WIDTH-1:0]   a_nxt;
    logic [N*WIDTH-1:0]   b_nxt;
    logic [N-1:0]         a_v_nxt;
    logic [N-1:0]         b_v_nxt;
    logic                 accept;

    assign accept = START && (state == ST_IDLE || state == ST_FIN);

    // Lanes are computed for the step about to be shown, so outputs can stay registered
    assign t_next = (state == ST_LOAD) ? '0 : step + 1'b1;

    for (genvar g = 0; g < N; g++) begin : g_lane
        skew_lane_sel #(.WIDTH(WIDTH), .N(N), .LANE(g)) u_a_sel (
            .t     (t_next),
            .vec   (a_cap[a_elem_lsb(N, WIDTH, g, N-1) +: N*WIDTH]),
            .valid (a_v_nxt[g]),
            .elem  (a_nxt[(N-1-g)*WIDTH +: WIDTH])
        );
        skew_lane_sel #(.WIDTH(WIDTH), .N(N), .LANE(g)) u_b_sel (
            .t     (t_next),
            .vec   (b_cap[b_elem_lsb(N, WIDTH, N-1, g) +: N*WIDTH]),
            .valid (b_v_nxt[g]),
            .elem  (b_nxt[(N-1-g)*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            step      <= '0;
            drain_cnt <= '0;
            a_cap     <= '0;
            b_cap     <= '0;
            A_OUT     <= '0;
            B_OUT     <= '0;
            A_VALID   <= '0;
            B_VALID   <= '0;
            CLEAR     <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            CLEAR <= 1'b0;
            DONE  <= 1'b0;
            if (accept) begin
                state <= ST_LOAD;
                step  <= '0;
                a_cap <= A_IN;
                b_cap <= B_IN;
                CLEAR <= 1'b1;
                BUSY  <= 1'b1;
            end else begin
                case (state)
                    ST_LOAD: begin
                        state   <= ST_FEED;
                        step    <= '0;
                        A_OUT   <= a_nxt;
                        B_OUT   <= b_nxt;
                        A_VALID <= a_v_nxt;
                        B_VALID <= b_v_nxt;
                    end
                    ST_FEED: begin
                        if (!STALL) begin
                            if (step == CNT_W'(FEED_LEN - 1)) begin
                                state     <= ST_DRAIN;
                                drain_cnt <= '0;
                                A_OUT     <= '0;
                                B_OUT     <= '0;
                                A_VALID   <= '0;
                                B_VALID   <= '0;
                            end else begin
                                step    <= t_next;
                                A_OUT   <= a_nxt;
                                B_OUT   <= b_nxt;
                                A_VALID <= a_v_nxt;
                                B_VALID <= b_v_nxt;
                            end
                        end
                    end
                    ST_DRAIN: begin
                        if (!STALL) begin
                            if (drain_cnt == DRN_W'(DRAIN_CYCLES - 1)) begin
                                state <= ST_FIN;
                                BUSY  <= 1'b0;
                                DONE  <= 1'b1;
                            end else begin
                                drain_cnt <= drain_cnt + 1'b1;
                            end
                        end
                    end
                    ST_FIN:  state <= ST_IDLE;
                    ST_IDLE: state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Self-checking bench: timeline-based reference model plus directed literal scenarios.
module tb_systolic_skew_feeder;

    localparam int N    = 3;
    localparam int W    = 4;
    localparam int DR   = 3;
    localparam int FINP = 2 * N + DR;
    localparam int N2   = 4;
    localparam int W2   = 8;
    localparam int DR2  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic [N*N*W-1:0] a_in = '0;
    logic [N*N*W-1:0] b_in = '0;
    logic [N*W-1:0]   a_out, b_out;
    logic [N-1:0]     a_valid, b_valid;
    logic             clear, busy, done;

    logic start2 = 1'b0;
    logic [N2*N2*W2-1:0] a_in2 = '0;
    logic [N2*N2*W2-1:0] b_in2 = '0;
    logic [N2*W2-1:0]    a_out2, b_out2;
    logic [N2-1:0]       a_valid2, b_valid2;
    logic                clear2, busy2, done2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_skew_feeder #(.WIDTH(W), .N(N), .DRAIN_CYCLES(DR)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .STALL(stall),
        .A_IN(a_in), .B_IN(b_in), .A_OUT(a_out), .B_OUT(b_out),
        .A_VALID(a_valid), .B_VALID(b_valid), .CLEAR(clear), .BUSY(busy), .DONE(done)
    );

    systolic_skew_feeder #(.WIDTH(W2), .N(N2), .DRAIN_CYCLES(DR2)) dut2 (
        .CLK(clk), .RST_N(rst_n), .START(start2), .STALL(1'b0),
        .A_IN(a_in2), .B_IN(b_in2), .A_OUT(a_out2), .B_OUT(b_out2),
        .A_VALID(a_valid2), .B_VALID(b_valid2), .CLEAR(clear2), .BUSY(busy2), .DONE(done2)
    );

    // Reference: position on the nominal run timeline, frozen by stalls in FEED/DRAIN
    bit          m_active = 1'b0;
    int          m_pos = 0;
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active = 1'b0;
        end else if (start && (!m_active || m_pos == FINP)) begin
            m_active = 1'b1;
            m_pos = 0;
            for (int r = 0; r < N; r++)
                for (int k = 0; k < N; k++) begin
                    ma[r][k] = a_in[(N*N-1-(r*N+k))*W +: W];
                    mb[k][r] = b_in[(N*N-1-(r*N+k))*W +: W];
                end
        end else if (m_active) begin
            if (m_pos == FINP) m_active = 1'b0;
            else if (!(stall && m_pos >= 1)) m_pos++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        logic [N*W-1:0] ea, eb;
        logic [N-1:0]   eav, ebv;
        logic           ec, ebusy, ed;
        int             t;
        forever begin
            @(posedge clk);
            #2;
            ea = '0; eb = '0; eav = '0; ebv = '0; ec = 1'b0; ebusy = 1'b0; ed = 1'b0;
            if (m_active) begin
                if (m_pos == 0) begin
                    ec = 1'b1;
                    ebusy = 1'b1;
                end else if (m_pos <= 2 * N - 1) begin
                    ebusy = 1'b1;
                    t = m_pos - 1;
                    for (int r = 0; r < N; r++) begin
                        if (t - r >= 0 && t - r < N) begin
                            ea[(N-1-r)*W +: W] = ma[r][t-r];
                            eav[r] = 1'b1;
                            eb[(N-1-r)*W +: W] = mb[t-r][r];
                            ebv[r] = 1'b1;
                        end
                    end
                end else if (m_pos < FINP) begin
                    ebusy = 1'b1;
                end else begin
                    ed = 1'b1;
                end
            end
            check("model_cycle", {a_out, b_out, a_valid, b_valid, clear, busy, done},
                  {ea, eb, eav, ebv, ec, ebusy, ed});
        end
    endtask

    logic [11:0] a_tab [5] = '{12'h100, 12'h240, 12'h357, 12'h068, 12'h009};
    logic [11:0] b_tab [5] = '{12'h900, 12'h860, 12'h753, 12'h042, 12'h001};

    task automatic run_one(input int st0, input int stn, input int exp_done, input bit poke);
        int eff;
        bit seen;
        @(negedge clk);
        a_in = 36'h123456789;
        b_in = 36'h987654321;
        stall = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("clear_c0", clear, 1);
        check("busy_c0", busy, 1);
        seen = 1'b0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clk);
            stall = (k >= st0 && k < st0 + stn);
            if (poke && k == 3) begin
                start = 1'b1;
                a_in = 36'({$urandom(), $urandom()});
                b_in = 36'({$urandom(), $urandom()});
            end else begin
                start = 1'b0;
            end
            eff = k - ((k < st0) ? 0 : ((k - st0 < stn) ? k - st0 : stn));
            if (eff >= 1 && eff <= 5) begin
                check("a_out_step", a_out, a_tab[eff-1]);
                check("b_out_step", b_out, b_tab[eff-1]);
            end
            if (done) begin
                seen = 1'b1;
                check("done_cycle", k, exp_done);
            end
        end
        stall = 1'b0;
        start = 1'b0;
        check("done_seen", seen, 1);
    endtask

    initial begin
        int  n;
        bit  seen_done;
        logic [127:0] exp2;
        int  t;

        fork
            compare_loop();
        join_none

        repeat (3) @(negedge clk);
        check("reset_outputs", {a_out, b_out, a_valid, b_valid, clear, busy, done}, '0);
        check("reset_outputs2", {a_out2, b_out2, a_valid2, b_valid2, clear2, busy2, done2}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, stalled run, and a run with ignored START plus A_IN change
        run_one(0, 0, 9, 1'b0);
        run_one(2, 2, 11, 1'b0);
        run_one(0, 0, 9, 1'b1);

        // Back-to-back with START held high; new A_IN presented in the FIN cycle
        @(negedge clk);
        a_in = 36'h123456789;
        b_in = 36'h987654321;
        start = 1'b1;
        n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_done", done, 1);
        a_in = 36'hfedcba987;
        b_in = 36'h13579bdf0;
        @(negedge clk);
        check("b2b_clear_after_done", {clear, done}, 2'b10);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b_period", n, 10);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous abort in FEED
        a_in = 36'h123456789;
        b_in = 36'h987654321;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy_before_abort", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset", {a_out, b_out, a_valid, b_valid, clear, busy, done}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        repeat (15) begin
            @(negedge clk);
            seen_done |= done;
        end
        check("no_done_after_abort", seen_done, 0);
        run_one(0, 0, 9, 1'b0);

        // N=4, WIDTH=8: identity A, all-ones B
        for (int r = 0; r < N2; r++)
            for (int k = 0; k < N2; k++)
                a_in2[(N2*N2-1-(r*N2+k))*W2 +: W2] = (r == k) ? 8'h01 : 8'h00;
        b_in2 = '1;
        @(negedge clk);
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            if (k > 0) @(negedge clk);
            exp2 = '0;
            begin
                logic [N2*W2-1:0] ea2, eb2;
                logic [N2-1:0]    eav2, ebv2;
                ea2 = '0; eb2 = '0; eav2 = '0; ebv2 = '0;
                if (k >= 1 && k <= 2 * N2 - 1) begin
                    t = k - 1;
                    for (int r = 0; r < N2; r++) begin
                        if (t - r >= 0 && t - r < N2) begin
                            ea2[(N2-1-r)*W2 +: W2] = (t - r == r) ? 8'h01 : 8'h00;
                            eb2[(N2-1-r)*W2 +: W2] = 8'hFF;
                            eav2[r] = 1'b1;
                            ebv2[r] = 1'b1;
                        end
                    end
                end
                exp2 = {ea2, eb2, eav2, ebv2, (k == 0), (k <= 2 * N2 + DR2 - 1), (k == 2 * N2 + DR2)};
            end
            check("n4_cycle", {a_out2, b_out2, a_valid2, b_valid2, clear2, busy2, done2}, exp2);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 99) < 30);
            stall = ($urandom_range(0, 99) < 25);
            a_in  = 36'({$urandom(), $urandom()});
            b_in  = 36'({$urandom(), $urandom()});
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk);
        start = 1'b0;
        stall = 1'b0;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
